// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle between the PC sequencer, the combinational instruction ROM
// and the decode/branch unit.
//   master : fetch_ctrl view; drives instr_addr, instr_out, instr_valid, done, icount
//   slave  : environment view (ROM, decoder, branch unit, bench); drives the rest
// Signals:
//   start, stall, halt_req        control from the core/decoder
//   branch_en, branch_off         relative branch request, two's-complement offset
//   jump_en, jump_addr            absolute jump request
//   instr_addr / instr_in         ROM address / ROM read data
//   instr_out, instr_valid        instruction presented to decode
//   done, icount                  halt flag and retired-instruction count
interface fetch_ctrl_if #(
  parameter int unsigned rom_size    = 256,
  parameter int unsigned instr_width = 9
);
  localparam int unsigned AW = $clog2(rom_size);

  logic                   start;
  logic                   stall;
  logic                   halt_req;
  logic                   branch_en;
  logic [AW-1:0]          branch_off;
  logic                   jump_en;
  logic [AW-1:0]          jump_addr;
  logic [AW-1:0]          instr_addr;
  logic [instr_width-1:0] instr_in;
  logic [instr_width-1:0] instr_out;
  logic                   instr_valid;
  logic                   done;
  logic [15:0]            icount;

  modport master (
    input  start, stall, halt_req, branch_en, branch_off, jump_en, jump_addr, instr_in,
    output instr_addr, instr_out, instr_valid, done, icount
  );

  modport slave (
    output start, stall, halt_req, branch_en, branch_off, jump_en, jump_addr, instr_in,
    input  instr_addr, instr_out, instr_valid, done, icount
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the single-cycle core. Owns the PC, drives the
// combinational ROM address, presents the fetched word to decode and runs an
// IDLE/RUN/HALT state machine so the environment can tell when a program ends.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; beats every other input
//   bus    fetch_ctrl_if.master (control inputs, ROM port, decode outputs)
// Build option:
//   FETCH_ICOUNT_EN  when defined, icount counts retired instructions (saturating
//                    at 0xFFFF); otherwise icount is tied to zero and has no flops.
module fetch_ctrl #(
  parameter int unsigned rom_size    = 256,
  parameter int unsigned instr_width = 9
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  localparam int unsigned AW = $clog2(rom_size);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic          valid_q;
  logic          done_q;

  // Single-process FSM; valid/done are registered alongside the state so they
  // always match it without decoding on the output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StRun;
            pc_q    <= '0;
            valid_q <= 1'b1;
          end
        end
        StRun: begin
          if (bus.halt_req) begin
            state_q <= StHalt;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (bus.stall) begin
            pc_q <= pc_q;
          end else if (bus.jump_en) begin
            pc_q <= bus.jump_addr;
          end else if (bus.branch_en) begin
            // AW-bit add: wraps modulo rom_size, negative offsets are two's complement
            pc_q <= pc_q + bus.branch_off;
          end else begin
            pc_q <= pc_q + AW'(1);
          end
        end
        StHalt: begin
          if (bus.start) begin
            state_q <= StRun;
            pc_q    <= '0;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          pc_q    <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_addr  = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.done        = done_q;
  // ROM is combinational, so the word for the current PC is passed straight through.
  assign bus.instr_out   = (state_q == StRun) ? bus.instr_in : '0;

`ifdef FETCH_ICOUNT_EN
  logic [15:0] icount_q;
  logic        retire;
  logic        restart;

  assign retire  = (state_q == StRun) && !bus.stall && !bus.halt_req;
  assign restart = ((state_q == StIdle) || (state_q == StHalt)) && bus.start;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      icount_q <= '0;
    end else if (retire && (icount_q != 16'hFFFF)) begin
      icount_q <= icount_q + 16'd1;
    end
  end

  assign bus.icount = icount_q;
`else
  assign bus.icount = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, branch/jump priority,
// wrap-around, stall, halt/restart and reset mid-run. Expected icount values
// follow the FETCH_ICOUNT_EN build option.
module tb_fetch_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  fetch_ctrl_if #(.rom_size(256), .instr_width(9)) bus ();

  fetch_ctrl #(.rom_size(256), .instr_width(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a simple, address-distinct pattern.
  function automatic logic [8:0] rom_word(input logic [7:0] a);
    return {1'b1, a ^ 8'h5A};
  endfunction

  assign bus.instr_in = rom_word(bus.instr_addr);

  function automatic logic [31:0] exp_ic(input int n);
`ifdef FETCH_ICOUNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctrl();
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    bus.halt_req   = 1'b0;
    bus.branch_en  = 1'b0;
    bus.branch_off = 8'h00;
    bus.jump_en    = 1'b0;
    bus.jump_addr  = 8'h00;
  endtask

  task automatic jump_to(input logic [7:0] a);
    bus.jump_en   = 1'b1;
    bus.jump_addr = a;
    step();
    bus.jump_en   = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_ctrl();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_addr", 32'(bus.instr_addr), 32'h0);
    check("rst_instr", 32'(bus.instr_out), 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_icount", 32'(bus.icount), 32'h0);

    // IDLE ignores jumps
    jump_to(8'd33);
    check("idle_addr", 32'(bus.instr_addr), 32'h0);
    check("idle_valid", 32'(bus.instr_valid), 32'h0);

    // Start, then sequential fetch 0..4
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_valid", 32'(bus.instr_valid), 32'h1);
    check("start_done", 32'(bus.done), 32'h0);
    check("seq_addr0", 32'(bus.instr_addr), 32'h0);
    check("seq_instr0", 32'(bus.instr_out), 32'(rom_word(8'd0)));
    check("seq_icount0", 32'(bus.icount), exp_ic(0));
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_addr", 32'(bus.instr_addr), 32'(i));
      check("seq_instr", 32'(bus.instr_out), 32'(rom_word(8'(i))));
    end
    step();
    check("seq_addr5", 32'(bus.instr_addr), 32'd5);
    check("seq_icount5", 32'(bus.icount), exp_ic(5));

    // Branch back by 4 from PC 10
    jump_to(8'd10);
    check("jmp_addr10", 32'(bus.instr_addr), 32'd10);
    check("jmp_icount", 32'(bus.icount), exp_ic(6));
    bus.branch_en  = 1'b1;
    bus.branch_off = 8'hFC;
    step();
    bus.branch_en  = 1'b0;
    check("br_addr6", 32'(bus.instr_addr), 32'd6);
    check("br_instr6", 32'(bus.instr_out), 32'(rom_word(8'd6)));

    // Jump beats branch
    bus.branch_en  = 1'b1;
    bus.branch_off = 8'hFC;
    jump_to(8'd40);
    bus.branch_en  = 1'b0;
    check("jmp_beats_br", 32'(bus.instr_addr), 32'd40);
    check("jmp_instr40", 32'(bus.instr_out), 32'(rom_word(8'd40)));
    check("jmp_icount8", 32'(bus.icount), exp_ic(8));

    // Wrap-around forward and via negative branch
    jump_to(8'd255);
    check("wrap_255", 32'(bus.instr_addr), 32'd255);
    step();
    check("wrap_0", 32'(bus.instr_addr), 32'd0);
    step();
    step();
    check("wrap_2", 32'(bus.instr_addr), 32'd2);
    bus.branch_en  = 1'b1;
    bus.branch_off = 8'hFD;
    step();
    bus.branch_en  = 1'b0;
    check("br_wrap_255", 32'(bus.instr_addr), 32'd255);
    check("br_wrap_icount", 32'(bus.icount), exp_ic(13));

    // Stall for 3 cycles at PC 7
    jump_to(8'd7);
    check("stall_pre", 32'(bus.instr_addr), 32'd7);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", 32'(bus.instr_addr), 32'd7);
      check("stall_instr", 32'(bus.instr_out), 32'(rom_word(8'd7)));
      check("stall_icount", 32'(bus.icount), exp_ic(14));
    end
    bus.stall = 1'b0;
    step();
    check("stall_release", 32'(bus.instr_addr), 32'd8);
    check("stall_rel_icount", 32'(bus.icount), exp_ic(15));

    // Halt together with stall at PC 12
    jump_to(8'd12);
    check("halt_pre", 32'(bus.instr_addr), 32'd12);
    bus.halt_req = 1'b1;
    bus.stall    = 1'b1;
    step();
    bus.halt_req = 1'b0;
    bus.stall    = 1'b0;
    check("halt_done", 32'(bus.done), 32'h1);
    check("halt_valid", 32'(bus.instr_valid), 32'h0);
    check("halt_instr", 32'(bus.instr_out), 32'h0);
    check("halt_addr", 32'(bus.instr_addr), 32'd12);
    check("halt_icount", 32'(bus.icount), exp_ic(16));
    jump_to(8'd99);
    check("halt_hold_addr", 32'(bus.instr_addr), 32'd12);
    check("halt_hold_done", 32'(bus.done), 32'h1);

    // Restart from HALT
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_valid", 32'(bus.instr_valid), 32'h1);
    check("restart_done", 32'(bus.done), 32'h0);
    check("restart_addr", 32'(bus.instr_addr), 32'd0);
    check("restart_icount", 32'(bus.icount), exp_ic(0));

    // start while RUN has no effect
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("run_start_addr", 32'(bus.instr_addr), 32'd1);
    check("run_start_icount", 32'(bus.icount), exp_ic(1));

    // Reset mid-run at PC 20, with start in the same cycle
    jump_to(8'd20);
    check("mid_pre", 32'(bus.instr_addr), 32'd20);
    reset     = 1'b1;
    bus.start = 1'b1;
    step();
    reset     = 1'b0;
    bus.start = 1'b0;
    check("mid_rst_addr", 32'(bus.instr_addr), 32'h0);
    check("mid_rst_valid", 32'(bus.instr_valid), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    check("mid_rst_instr", 32'(bus.instr_out), 32'h0);
    check("mid_rst_icount", 32'(bus.icount), 32'h0);
    step();
    check("mid_rst_still_idle", 32'(bus.instr_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter sequencer that drives the address port of the combinational instruction ROM and presents the fetched instruction to the decode stage. It owns the PC, applies sequential, relative-branch and absolute-jump updates, honours decode stalls, and runs a start/run/halt state machine that tells the testbench when a program has finished. It sits between the ROM and the decoder/branch unit in the single-cycle core.

## Interface
- `rom_size`, 256: ROM depth in words, power of two. `AW = $clog2(rom_size)`.
- `instr_width`, 9: instruction word width in bits.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin execution at address 0.
- `stall`  in  1: hold the PC and the current instruction.
- `halt_req`  in  1: decoder saw the halt opcode.
- `branch_en`  in  1: take the relative branch.
- `branch_off`  in  AW: two's-complement offset added to the PC.
- `jump_en`  in  1: take the absolute jump.
- `jump_addr`  in  AW: absolute target.
- `instr_addr`  out  AW: ROM address, equal to the PC.
- `instr_in`  in  instr_width: ROM read data.
- `instr_out`  out  instr_width: instruction to decode.
- `instr_valid`  out  1: `instr_out` is live (state RUN).
- `done`  out  1: state HALT.
- `icount`  out  16: retired-instruction count.

## Operation
- States are IDLE, RUN and HALT. Reset enters IDLE.
- IDLE: on `start`, go to RUN with PC=0. Other inputs are ignored.
- RUN: `instr_valid`=1. Each cycle the PC updates by this priority:
  1. `halt_req`: go to HALT, PC holds.
  2. `stall`: PC holds.
  3. `jump_en`: PC=`jump_addr`.
  4. `branch_en`: PC=PC+`branch_off`.
  5. Otherwise: PC=PC+1.
- All PC arithmetic is AW bits, modulo `rom_size`. Wrap-around is legal and silent: 255+1 gives 0, and 2+(-3) gives 255.
- A cycle retires its instruction when the state is RUN, `stall`=0 and `halt_req`=0. A halt cycle does not retire.
- HALT: `done`=1 and the PC holds. `start` re-enters RUN with PC=0.
- `start` asserted while in RUN has no effect.
- `instr_out` passes `instr_in` combinationally when state is RUN. Otherwise it is 0.

## Timing
- Reset values:
  - state IDLE
  - PC 0, so `instr_addr`=0
  - `instr_out`=0
  - `instr_valid`=0
  - `done`=0
  - `icount`=0
- Reset asserted mid-RUN or in HALT forces all of the above on the next edge. It has priority over every other input.
- Fetch latency:
  - The ROM is combinational, so `instr_out` is valid in the same cycle that `instr_addr` changes.
  - The PC update is registered, so a redirect presented in cycle N sets `instr_addr` to the target in cycle N+1.
  - There is no delay slot and no bubble.
- `start` seen in IDLE in cycle N gives RUN with `instr_valid`=1 and `instr_addr`=0 in cycle N+1.
- `halt_req` in cycle N gives `done`=1 and `instr_valid`=0 in cycle N+1.
- `stall` gates only the PC and retirement. `instr_out` keeps tracking the held address.
- Simultaneous events:
  - `halt_req` beats `stall`, `jump_en` and `branch_en`.
  - `jump_en` beats `branch_en`.

## Configuration
- `FETCH_ICOUNT_EN` defined:
  - `icount` increments by 1 on every retiring cycle.
  - It saturates at 0xFFFF.
  - It clears to 0 on reset and on the `start` transition into RUN.
  - It holds in HALT so the bench can read it.
- `FETCH_ICOUNT_EN` undefined:
  - `icount` is tied to 0.
  - No counter flops are synthesised.
  - Every other behaviour is identical.

## Test plan
- Sequential fetch: reset, then `start` for 1 cycle, then RUN for 5 cycles. Required: `instr_addr` reads 0,1,2,3,4 and `instr_out` equals the ROM contents at each address. With the macro defined, `icount`=5.
- Branch and jump: at PC=10 apply `branch_off`=-4, giving PC 6 next cycle. At PC=6 apply `jump_en` with `jump_addr`=40 and `branch_en` both asserted, giving PC 40 (jump wins).
- Wrap-around: `jump_addr`=255, then free-run, giving PC 255 then 0. At PC=2 apply `branch_off`=-3, giving PC 255.
- Stall: `stall` held for 3 cycles at PC=7. Required: PC stays 7, `instr_out` is stable and `icount` does not change. On release the PC goes to 8.
- Halt and restart:
  - Assert `halt_req` together with `stall` at PC=12.
  - Next cycle: `done`=1, `instr_valid`=0, `instr_out`=0, PC=12, and `icount` is unchanged.
  - Then pulse `start`: RUN with PC=0 and `icount`=0.
- Reset mid-run: assert `reset` at PC=20 in RUN. Next cycle: IDLE, PC=0, all outputs 0. `start` in that same cycle is ignored.
